// File: rtl/sm3_round_ctrl.sv
// SM3 compression round sequencer: load, 64 rounds, final V xor, hold.
// Drives the shared round datapath and supplies the rotated T_j constant.
module sm3_round_ctrl #(
    parameter int unsigned NUM_ROUNDS   = 64,
    parameter int unsigned SWITCH_ROUND = 16,
    parameter logic [31:0] TJ_LO        = 32'h79CC4519,
    parameter logic [31:0] TJ_HI        = 32'h7A879D8A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_first,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        iv_sel,
    output logic        ld_init,
    output logic        rnd_en,
    output logic        w_shift,
    output logic        ff_sel,
    output logic [5:0]  round_idx,
    output logic [31:0] tj_rot,
    output logic        fin_en,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        HOLD
    } state_t;

    function automatic logic [31:0] rotl(input logic [31:0] v,
                                         input int unsigned s);
        return (v << s) | (v >> (32 - s));
    endfunction

    localparam logic [5:0]  LAST     = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0]  SW       = 6'(SWITCH_ROUND);
    localparam logic [5:0]  SW_LAST  = 6'(SWITCH_ROUND - 1);
    localparam logic [31:0] TJ_HI_SW = rotl(TJ_HI, SWITCH_ROUND % 32);

    state_t state, state_nxt;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ld_init   = 1'b0;
        rnd_en    = 1'b0;
        fin_en    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LOAD;
            end
            LOAD: begin
                ld_init   = 1'b1;
                state_nxt = ROUND;
            end
            ROUND: begin
                rnd_en = 1'b1;
                if (round_idx == LAST) state_nxt = FINAL;
            end
            FINAL: begin
                fin_en    = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign w_shift = rnd_en;
    assign ff_sel  = rnd_en && (round_idx >= SW);
    assign busy    = !in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_idx <= '0;
            tj_rot    <= '0;
            iv_sel    <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        iv_sel    <= in_first;
                        round_idx <= '0;
                        tj_rot    <= TJ_LO;
                    end
                end
                ROUND: begin
                    // The last round leaves index and constant in place.
                    if (round_idx != LAST) begin
                        round_idx <= round_idx + 6'd1;
                        if (round_idx == SW_LAST)
                            tj_rot <= TJ_HI_SW;
                        else
                            tj_rot <= {tj_rot[30:0], tj_rot[31]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_round_ctrl.sv
// Scoreboard bench for sm3_round_ctrl: accepted jobs are queued with
// their acceptance cycle; a negedge monitor checks the whole timeline.
module tb_sm3_round_ctrl;

    localparam logic [31:0] LO = 32'h79CC4519;
    localparam logic [31:0] HI = 32'h7A879D8A;
    localparam int PERIOD = 68;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, iv_sel, ld_init;
    logic        rnd_en, w_shift, ff_sel, fin_en, busy;
    logic [5:0]  round_idx;
    logic [31:0] tj_rot;

    sm3_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .iv_sel    (iv_sel),
        .ld_init   (ld_init),
        .rnd_en    (rnd_en),
        .w_shift   (w_shift),
        .ff_sel    (ff_sel),
        .round_idx (round_idx),
        .tj_rot    (tj_rot),
        .fin_en    (fin_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv;
        int   acc;
    } job_t;

    job_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_seen = 1'b1;
    logic b2b = 1'b0;
    int   last_ld = -1;
    int   n_ld = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] tref(input int j);
        logic [31:0] t;
        int s;
        t = (j < 16) ? LO : HI;
        s = j % 32;
        if (s == 0) return t;
        return (t << s) | (t >> (32 - s));
    endfunction

    always @(posedge clk) begin
        rst_seen = rst;
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready)
                sb.push_back('{iv: in_first, acc: cyc});
            if (out_valid && out_ready) begin
                if (sb.size() == 0)
                    chk("spurious_out", 32'd1, 32'd0);
                else
                    void'(sb.pop_front());
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        int off, j;
        logic rnd;
        if (cyc > 0) begin
            chk("overlap", 32'($countones({ld_init, rnd_en, fin_en})) <= 1, 1);
            if (rst_seen) begin
                chk("rst_ready", in_ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_strb", {ld_init, rnd_en, w_shift, ff_sel,
                                 fin_en, out_valid}, 0);
                chk("rst_tj", tj_rot, 0);
                chk("rst_idx", round_idx, 0);
                chk("rst_iv", iv_sel, 0);
            end else if (sb.size() == 0) begin
                chk("idle_ready", in_ready, 1);
                chk("idle_busy", busy, 0);
                chk("idle_strb", {ld_init, rnd_en, w_shift, ff_sel,
                                  fin_en, out_valid}, 0);
            end else begin
                off = cyc - sb[0].acc;
                j   = off - 2;
                rnd = (off >= 2) && (off <= 65);
                chk("in_ready", in_ready, 0);
                chk("busy", busy, 1);
                chk("iv_sel", iv_sel, sb[0].iv);
                chk("ld_init", ld_init, off == 1);
                chk("rnd_en", rnd_en, rnd);
                chk("w_shift", w_shift, rnd);
                chk("fin_en", fin_en, off == 66);
                chk("out_valid", out_valid, off >= 67);
                chk("ff_sel", ff_sel, rnd && (j >= 16));
                if (off == 1) begin
                    chk("load_idx", round_idx, 0);
                    chk("load_tj", tj_rot, LO);
                end else if (rnd) begin
                    chk("round_idx", round_idx, j);
                    chk("tj_rot", tj_rot, tref(j));
                    case (j)
                        0:  chk("tj_j0", tj_rot, 32'h79CC4519);
                        1:  chk("tj_j1", tj_rot, 32'hF3988A32);
                        16: chk("tj_j16", tj_rot, 32'h9D8A7A87);
                        32: chk("tj_j32", tj_rot, 32'h7A879D8A);
                        63: chk("tj_j63", tj_rot, 32'h3D43CEC5);
                        default: ;
                    endcase
                end else begin
                    chk("hold_idx", round_idx, 63);
                    chk("hold_tj", tj_rot, 32'h3D43CEC5);
                end
            end
            if (!b2b) begin
                last_ld = -1;
            end else if (ld_init) begin
                if (last_ld >= 0) chk("ld_period", cyc - last_ld, PERIOD);
                last_ld = cyc;
                n_ld++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && sb.size() != 0; i++) step(1);
        chk(tag, sb.size(), 0);
    endtask

    task automatic start_job(input logic first);
        in_first = first;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        chk("accepted", sb.size(), 1);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(2);

        // job 1: first block, consumer stalls for 10 cycles
        out_ready = 1'b0;
        start_job(1'b1);
        for (int i = 0; i < 200 && !out_valid; i++) step(1);
        chk("ov_wait", out_valid, 1);
        in_valid = 1'b1;
        in_first = 1'b0;
        step(10);
        chk("ov_stall", out_valid, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("hold_exit", sb.size(), 0);
        step(2);

        // job 2: chaining block
        out_ready = 1'b1;
        start_job(1'b0);
        drain("drain2");
        step(2);

        // job 3: abandoned by reset at round 40
        start_job(1'b1);
        for (int i = 0; i < 200 && !(rnd_en && round_idx == 6'd40); i++)
            step(1);
        chk("reach_r40", round_idx, 40);
        rst      = 1'b1;
        in_valid = 1'b1;
        step(1);
        rst      = 1'b0;
        in_valid = 1'b0;
        step(80);
        chk("after_abort", sb.size(), 0);

        // job 4: fresh job after the abort
        start_job(1'b0);
        drain("drain4");
        step(2);

        // back-to-back stream
        b2b       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            in_first = 1'($urandom_range(0, 1));
            step(1);
        end
        in_valid = 1'b0;
        drain("drain_b2b");
        chk("b2b_jobs", n_ld >= 4, 1);
        b2b = 1'b0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
